vga_tile_indexer: RTL and testbench

//   Upstream stage of the VGA colour path. Generates 640x480@60 timing, maps each active pixel to a

---
 rtl/vga_tile_indexer.sv | 138 +++++++++++++
 tb/tb_vga_tile_indexer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_indexer.sv
// 640x480@60 timing generator that maps each active pixel to a tile-grid cell and fetches its
// 4-bit colour index from an external tile RAM. Sync/blank/colour leave on a common 2-tick pipeline.
module vga_tile_indexer #(
    parameter int unsigned HActive   = 640,
    parameter int unsigned HFp       = 16,
    parameter int unsigned HSync     = 96,
    parameter int unsigned HBp       = 48,
    parameter int unsigned VActive   = 480,
    parameter int unsigned VFp       = 10,
    parameter int unsigned VSync     = 2,
    parameter int unsigned VBp       = 33,
    parameter int unsigned TileShift = 5,
    parameter int unsigned GridW     = 20,
    parameter int unsigned GridH     = 15,
    parameter int unsigned AddrW     = 9,
    parameter logic [3:0]  BorderIdx = 4'hE,
    parameter logic [3:0]  BlankIdx  = 4'h7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pix_ce_i,
    output logic [AddrW-1:0] rd_addr_o,
    input  logic [3:0]       rd_data_i,
    output logic [3:0]       color_idx_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             blank_n_o,
    output logic             frame_start_o
);

    localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
    localparam int unsigned VTotal = VActive + VFp + VSync + VBp;
    localparam int unsigned HW     = $clog2(HTotal);
    localparam int unsigned VW     = $clog2(VTotal);

    // Stage 0: raster counters
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    // Stage 1: decoded position flags and tile RAM address
    logic             active_q, active_d;
    logic             in_grid_q, in_grid_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             first_q, first_d;
    logic [AddrW-1:0] rd_addr_q, rd_addr_d;

    // Stage 2: outputs
    logic       hsync_q, vsync_q, blank_n_q, frame_start_q, frame_start_d;
    logic [3:0] color_q, color_d;

    logic [HW-1:0] h_tile;
    logic [VW-1:0] v_tile;

    assign h_tile = h_cnt_q >> TileShift;
    assign v_tile = v_cnt_q >> TileShift;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(HTotal - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(VTotal - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    always_comb begin
        active_d  = (32'(h_cnt_q) < HActive) && (32'(v_cnt_q) < VActive);
        in_grid_d = (32'(h_tile) < GridW) && (32'(v_tile) < GridH);
        hs_d      = !((32'(h_cnt_q) >= HActive + HFp) && (32'(h_cnt_q) < HActive + HFp + HSync));
        vs_d      = !((32'(v_cnt_q) >= VActive + VFp) && (32'(v_cnt_q) < VActive + VFp + VSync));
        first_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
        // Outside the grid the address holds so the RAM sees no needless toggles.
        rd_addr_d = rd_addr_q;
        if (in_grid_d) begin
            rd_addr_d = AddrW'(32'(v_tile) * GridW + 32'(h_tile));
        end
    end

    always_comb begin
        color_d = rd_data_i;
        if (!active_q) begin
            color_d = BlankIdx;
        end else if (!in_grid_q) begin
            color_d = BorderIdx;
        end
        // Not gated by pix_ce in the register, so the pulse lasts exactly one clk.
        frame_start_d = pix_ce_i && first_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            active_q      <= 1'b0;
            in_grid_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            first_q       <= 1'b0;
            rd_addr_q     <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            color_q       <= BlankIdx;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
            if (pix_ce_i) begin
                h_cnt_q   <= h_cnt_d;
                v_cnt_q   <= v_cnt_d;
                active_q  <= active_d;
                in_grid_q <= in_grid_d;
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                first_q   <= first_d;
                rd_addr_q <= rd_addr_d;
                hsync_q   <= hs_q;
                vsync_q   <= vs_q;
                blank_n_q <= active_q;
                color_q   <= color_d;
            end
        end
    end

    assign rd_addr_o     = rd_addr_q;
    assign color_idx_o   = color_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign blank_n_o     = blank_n_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_tile_indexer.sv
// Directed bench: default-geometry instance plus a GridW=16 instance with a short vertical frame.
module tb_vga_tile_indexer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic pix_ce;

    logic [8:0] a_addr;
    logic [3:0] a_data, a_color;
    logic       a_hs, a_vs, a_blank, a_fs;
    logic [8:0] b_addr;
    logic [3:0] b_data, b_color;
    logic       b_hs, b_vs, b_blank, b_fs;

    // Tile RAM model: word at address A holds A[3:0]; rd_addr is the RAM's address register.
    assign a_data = a_addr[3:0];
    assign b_data = b_addr[3:0];

    vga_tile_indexer u_dut_a (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pix_ce_i      (pix_ce),
        .rd_addr_o     (a_addr),
        .rd_data_i     (a_data),
        .color_idx_o   (a_color),
        .hsync_o       (a_hs),
        .vsync_o       (a_vs),
        .blank_n_o     (a_blank),
        .frame_start_o (a_fs)
    );

    // 27-line frame keeps a full vertical cycle short.
    vga_tile_indexer #(
        .GridW   (16),
        .VActive (20),
        .VFp     (2),
        .VSync   (2),
        .VBp     (3)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pix_ce_i      (pix_ce),
        .rd_addr_o     (b_addr),
        .rd_data_i     (b_data),
        .color_idx_o   (b_color),
        .hsync_o       (b_hs),
        .vsync_o       (b_vs),
        .blank_n_o     (b_blank),
        .frame_start_o (b_fs)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hs_low, hs_first, a_fs_cnt, b_fs_cnt, b_fs2, b_vs_low, b_vs_first;

    initial begin
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        repeat (3) tick();
        check_eq("rst_color", a_color, 4'h7);
        check_eq("rst_blank", a_blank, 1'b0);
        check_eq("rst_hsync", a_hs, 1'b1);
        check_eq("rst_vsync", a_vs, 1'b1);
        check_eq("rst_fs", a_fs, 1'b0);
        check_eq("rst_addr", a_addr, 9'd0);

        // Continuous pix_ce from reset release
        hs_low = 0; hs_first = 0; a_fs_cnt = 0; b_fs_cnt = 0; b_fs2 = 0;
        b_vs_low = 0; b_vs_first = 0;
        rst_n  = 1'b1;
        pix_ce = 1'b1;
        for (int t = 1; t <= 51202; t++) begin
            tick();
            if (t == 1) begin
                check_eq("t1_fs", a_fs, 1'b0);
                check_eq("t1_blank", a_blank, 1'b0);
            end
            if (t == 2) begin
                check_eq("t2_fs", a_fs, 1'b1);
                check_eq("t2_color", a_color, 4'h0);
                check_eq("t2_blank", a_blank, 1'b1);
                check_eq("t2_fs_b", b_fs, 1'b1);
            end
            if (t == 3) check_eq("t3_fs", a_fs, 1'b0);
            if (t == 34) check_eq("px33_addr", a_addr, 9'd1);
            if (t == 35) check_eq("px33_color", a_color, 4'h1);
            if (t == 51201) check_eq("px0_64_addr", a_addr, 9'd40);
            if (t == 51202) begin
                check_eq("px0_64_color", a_color, 4'h8);
                check_eq("px0_64_blank", a_blank, 1'b1);
            end
            if (t == 8502) check_eq("b_px500_color", b_color, 4'hF);
            if (t == 8602) begin
                check_eq("b_px600_color", b_color, 4'hE);
                check_eq("b_px600_blank", b_blank, 1'b1);
            end
            if (t == 8702) begin
                check_eq("b_px700_color", b_color, 4'h7);
                check_eq("b_px700_blank", b_blank, 1'b0);
            end
            if (t >= 2 && t <= 801 && !a_hs) begin
                hs_low++;
                if (hs_first == 0) hs_first = t;
            end
            if (a_fs) a_fs_cnt++;
            if (b_fs) begin
                b_fs_cnt++;
                if (b_fs_cnt == 2) b_fs2 = t;
            end
            if (t <= 21601 && !b_vs) begin
                b_vs_low++;
                if (b_vs_first == 0) b_vs_first = t;
            end
        end
        check_eq("hs_low_len", hs_low, 96);
        check_eq("hs_first_tick", hs_first, 658);
        check_eq("a_fs_count", a_fs_cnt, 1);
        check_eq("b_fs_count", b_fs_cnt, 3);
        check_eq("b_fs_period", b_fs2 - 2, 21600);
        check_eq("b_vs_low_len", b_vs_low, 1600);
        check_eq("b_vs_first_tick", b_vs_first, 17602);

        // pix_ce high on every other clk
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        pix_ce = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            logic [3:0] ec;
            logic       eb;
            ec = (t < 2) ? 4'h7 : 4'((t - 2) >> 5);
            eb = (t >= 2);
            pix_ce = 1'b1;
            tick();
            check_eq($sformatf("ce2_color_%0d", t), a_color, ec);
            check_eq($sformatf("ce2_blank_%0d", t), a_blank, eb);
            check_eq($sformatf("ce2_fs_%0d", t), a_fs, (t == 2));
            pix_ce = 1'b0;
            tick();
            check_eq($sformatf("ce2_hold_%0d", t), a_color, ec);
            check_eq($sformatf("ce2_fs_low_%0d", t), a_fs, 1'b0);
        end

        // Reset asserted mid-frame at output pixel (300,20)
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        pix_ce = 1'b1;
        repeat (16302) tick();
        check_eq("mid_color", a_color, 4'h9);
        check_eq("mid_blank", a_blank, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_color", a_color, 4'h7);
        check_eq("arst_blank", a_blank, 1'b0);
        check_eq("arst_hsync", a_hs, 1'b1);
        check_eq("arst_vsync", a_vs, 1'b1);
        check_eq("arst_fs", a_fs, 1'b0);
        check_eq("arst_addr", a_addr, 9'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rel_t1_fs", a_fs, 1'b0);
        tick();
        check_eq("rel_t2_fs", a_fs, 1'b1);
        check_eq("rel_t2_color", a_color, 4'h0);
        check_eq("rel_t2_blank", a_blank, 1'b1);
        tick();
        check_eq("rel_t3_fs", a_fs, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
